// File: rtl/time_setter_if.sv
// time_setter_if: raw buttons and busy in, BCD preset digits, cursor and commit strobe out.
interface time_setter_if;
    logic       btnSel, btnUp, btnDown, btnLoad, busy;
    logic [3:0] setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1;
    logic       write;
    logic [2:0] cursor;
    logic       editing;
    modport master (
        output btnSel, btnUp, btnDown, btnLoad, busy,
        input  setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1,
        input  write, cursor, editing
    );
    modport slave (
        input  btnSel, btnUp, btnDown, btnLoad, busy,
        output setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1,
        output write, cursor, editing
    );
endinterface

// File: rtl/time_setter.sv
// time_setter: debounced push-button editor for HH:MM:SS preset digits with a one-cycle commit strobe.
module time_setter #(
    parameter int DEBOUNCE_CNT = 20000
) (
    input logic          clock,
    input logic          reset,
    time_setter_if.slave ts
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    typedef enum logic [1:0] {IDLE, EDIT, LOAD} state_t;
    state_t        st;
    logic [3:0]    raw, s1, s2, deb, press;
    logic [CW-1:0] cnt [4];
    logic [3:0]    cur, mx, nv;
    logic          ld, sel, up, dn;
    assign raw = {ts.btnLoad, ts.btnDown, ts.btnUp, ts.btnSel};
    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CNT - 1)) begin
                    cnt[i]   <= '0;
                    deb[i]   <= s2[i];
                    press[i] <= s2[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    // one action per cycle: Load > Sel > Up > Down
    assign ld  = press[3];
    assign sel = press[0] & ~ld;
    assign up  = press[1] & ~press[0] & ~ld;
    assign dn  = press[2] & ~press[1] & ~press[0] & ~ld;
    always_comb begin
        cur = ts.cursor == 3'd0 ? ts.setHour10 : ts.cursor == 3'd1 ? ts.setHour1 :
              ts.cursor == 3'd2 ? ts.setMinute10 : ts.cursor == 3'd3 ? ts.setMinute1 :
              ts.cursor == 3'd4 ? ts.setSecond10 : ts.setSecond1;
        mx  = ts.cursor == 3'd0 ? 4'd2 : ts.cursor == 3'd1 ? (ts.setHour10 == 4'd2 ? 4'd3 : 4'd9) :
              (ts.cursor == 3'd2 || ts.cursor == 3'd4) ? 4'd5 : 4'd9;
        nv  = up ? (cur == mx ? 4'd0 : cur + 4'd1) : (cur == 4'd0 ? mx : cur - 4'd1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            st             <= IDLE;
            ts.write       <= 1'b0;
            ts.editing     <= 1'b0;
            ts.cursor      <= '0;
            ts.setHour10   <= '0;
            ts.setHour1    <= '0;
            ts.setMinute10 <= '0;
            ts.setMinute1  <= '0;
            ts.setSecond10 <= '0;
            ts.setSecond1  <= '0;
        end else begin
            ts.write <= 1'b0;
            case (st)
                IDLE: begin
                    if (!ts.busy && ld) begin
                        st       <= LOAD;
                        ts.write <= 1'b1;
                    end else if (!ts.busy && sel) begin
                        st         <= EDIT;
                        ts.editing <= 1'b1;
                        ts.cursor  <= '0;
                    end
                end
                EDIT: begin
                    // busy aborts the edit without committing
                    if (ts.busy || ld) begin
                        st         <= ts.busy ? IDLE : LOAD;
                        ts.write   <= ~ts.busy;
                        ts.editing <= 1'b0;
                        ts.cursor  <= '0;
                    end else if (sel) ts.cursor <= ts.cursor == 3'd5 ? 3'd0 : ts.cursor + 3'd1;
                    else if (up || dn) begin
                        case (ts.cursor)
                            3'd0: begin
                                ts.setHour10 <= nv;
                                if (nv == 4'd2 && ts.setHour1 > 4'd3) ts.setHour1 <= 4'd3;
                            end
                            3'd1:    ts.setHour1    <= nv;
                            3'd2:    ts.setMinute10 <= nv;
                            3'd3:    ts.setMinute1  <= nv;
                            3'd4:    ts.setSecond10 <= nv;
                            default: ts.setSecond1  <= nv;
                        endcase
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: randomized and directed stimulus checked every cycle against a behavioural model.
module tb_time_setter;
    localparam int D = 4;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = '0;
    logic       busy = 1'b0;
    int         checks = 0, failures = 0, writes = 0, w0;
    bit         chk_en = 1'b0;

    time_setter_if ts ();
    assign ts.btnSel  = btn[0];
    assign ts.btnUp   = btn[1];
    assign ts.btnDown = btn[2];
    assign ts.btnLoad = btn[3];
    assign ts.busy    = busy;

    time_setter #(.DEBOUNCE_CNT(D)) dut (.clock(clock), .reset(reset), .ts(ts));

    always #5 clock = ~clock;

    // model: a button's debounced level flips once its last D synchronized samples all disagree with it
    bit [D:0]   hist [4];
    bit [3:0]   mdeb, pend, fl, rawm;
    int         mst, mcur, act, mx, v;
    int         dig [6];
    bit         mwrite, medit;

    function automatic int maxof(int c);
        return c == 0 ? 2 : c == 1 ? (dig[0] == 2 ? 3 : 9) : (c == 2 || c == 4) ? 5 : 9;
    endfunction

    always @(posedge clock) begin
        rawm = btn;
        if (reset) begin
            for (int b = 0; b < 4; b++) hist[b] = '0;
            for (int j = 0; j < 6; j++) dig[j] = 0;
            mdeb = '0; pend = '0; mst = 0; mcur = 0; mwrite = 0; medit = 0;
        end else begin
            act = pend[3] ? 3 : pend[0] ? 0 : pend[1] ? 1 : pend[2] ? 2 : -1;
            mwrite = 0;
            if (mst == 0) begin
                if (!busy && act == 3) begin mst = 2; mwrite = 1; end
                else if (!busy && act == 0) begin mst = 1; medit = 1; mcur = 0; end
            end else if (mst == 1) begin
                if (busy) begin mst = 0; medit = 0; mcur = 0; end
                else if (act == 3) begin mst = 2; mwrite = 1; medit = 0; mcur = 0; end
                else if (act == 0) mcur = (mcur + 1) % 6;
                else if (act == 1 || act == 2) begin
                    mx = maxof(mcur);
                    v = dig[mcur];
                    dig[mcur] = act == 1 ? (v + 1) % (mx + 1) : (v + mx) % (mx + 1);
                    if (dig[0] == 2 && dig[1] > 3) dig[1] = 3;
                end
            end else mst = 0;
            for (int b = 0; b < 4; b++) begin
                fl[b] = 1'b1;
                for (int k = 1; k <= D; k++) if (hist[b][k] == mdeb[b]) fl[b] = 1'b0;
                pend[b] = fl[b] & ~mdeb[b];
                if (fl[b]) mdeb[b] = ~mdeb[b];
                hist[b] = {hist[b][D-1:0], rawm[b]};
            end
        end
    end

    function automatic logic [28:0] outs();
        return {ts.setHour10, ts.setHour1, ts.setMinute10, ts.setMinute1, ts.setSecond10, ts.setSecond1,
                ts.write, ts.cursor, ts.editing};
    endfunction

    function automatic logic [28:0] model_vec();
        return {4'(dig[0]), 4'(dig[1]), 4'(dig[2]), 4'(dig[3]), 4'(dig[4]), 4'(dig[5]),
                mwrite, 3'(mcur), medit};
    endfunction

    function automatic logic [23:0] digs();
        return {ts.setHour10, ts.setHour1, ts.setMinute10, ts.setMinute1, ts.setSecond10, ts.setSecond1};
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if (outs() !== model_vec()) begin
                failures++;
                $display("FAIL cycle_compare t=%0t got=%h exp=%h", $time, outs(), model_vec());
            end
            if (ts.write) writes++;
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(int b);
        btn[b] = 1'b1;
        tick(8);
        btn[b] = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        reset = 1'b1; btn = '0; busy = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        chk_en = 1'b1;
        check("reset_state", 32'(outs()), 32'h0);
        reset = 1'b0;
        tick(1);
        // debounce: short glitch, then exact press latency
        btn[1] = 1'b1; tick(3); btn[1] = 1'b0; tick(12);
        check("glitch_ignored", 32'(outs()), 32'h0);
        btn[0] = 1'b1;
        tick(6);
        check("sel_latency_before", 32'(ts.editing), 32'h0);
        tick(1);
        check("sel_latency_at", 32'({ts.editing, ts.cursor}), 32'h8);
        tick(3); btn[0] = 1'b0; tick(10);
        // edit sequence and commit
        do_reset();
        press(0); press(1); press(1); press(0);
        repeat (5) press(1);
        check("edit_digits", 32'(digs()), 32'h210000);
        w0 = writes;
        press(3);
        check("load_one_write", 32'(writes - w0), 32'd1);
        check("load_idle", 32'({ts.editing, digs()}), 32'h0210000);
        // hour clamp
        do_reset();
        press(0); press(1); press(0);
        repeat (8) press(1);
        check("h18", 32'(digs()), 32'h180000);
        repeat (5) press(0);
        check("cursor_back0", 32'(ts.cursor), 32'd0);
        press(1);
        check("clamp_up", 32'(digs()), 32'h230000);
        press(1);
        check("h10_wrap", 32'(digs()), 32'h030000);
        press(0);
        repeat (5) press(1);
        repeat (5) press(0);
        press(2);
        check("clamp_down", 32'(digs()), 32'h230000);
        // wraps
        repeat (5) press(0);
        check("cursor5", 32'(ts.cursor), 32'd5);
        press(2);
        check("s1_wrap", 32'(digs()), 32'h230009);
        press(0);
        check("cursor_wrap", 32'(ts.cursor), 32'd0);
        repeat (2) press(0);
        press(2); press(1);
        check("m10_wrap", 32'(digs()), 32'h230009);
        repeat (2) press(0);
        press(2);
        check("s10_wrap", 32'(digs()), 32'h230059);
        // busy abort and lockout
        do_reset();
        repeat (3) press(0);
        press(1); press(0); press(1); press(1);
        check("pre_busy", 32'({ts.editing, digs()}), 32'h1001200);
        busy = 1'b1;
        tick(1);
        check("busy_abort", 32'({ts.editing, ts.cursor, digs()}), 32'h0001200);
        w0 = writes;
        press(0); press(3);
        check("busy_lockout", 32'({writes - w0, 4'(ts.editing)}), 32'h0);
        busy = 1'b0;
        tick(2);
        // simultaneous Load+Up, then reset in the LOAD cycle
        press(0);
        w0 = writes;
        btn = 4'b1010; tick(8); btn = '0; tick(8);
        check("load_beats_up", 32'({8'(writes - w0), digs()}), 32'h01001200);
        btn[3] = 1'b1;
        for (int i = 0; i < 20 && !ts.write; i++) tick(1);
        check("load_seen", 32'(ts.write), 32'd1);
        reset = 1'b1; btn = '0;
        tick(1);
        check("reset_in_load", 32'(outs()), 32'h0);
        reset = 1'b0;
        tick(2);
        // random soak
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            if (busy ? $urandom_range(0, 9) == 0 : $urandom_range(0, 79) == 0) busy = ~busy;
            reset = $urandom_range(0, 599) == 0;
            tick(1);
        end
        reset = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
